// File: rtl/dna_pkg.sv
// Shared definitions for the device-DNA port responder and the DNA reader.
// Both ends take the serial length from here so they agree on 57 bits.
package dna_pkg;

   localparam int DNA_WIDTH     = 57;
   localparam int DNA_CNT_W     = 7;

   // Reader side: bits captured per read and SHIFT pulses needed after READ
   // (the first bit is already on DOUT after the READ edge).
   localparam int DNA_RD_BITS   = DNA_WIDTH;
   localparam int DNA_RD_SHIFTS = DNA_WIDTH - 1;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOADED    = 2'd1,
      ST_SHIFTING  = 2'd2,
      ST_EXHAUSTED = 2'd3
   } dna_state_e;

   function automatic logic [DNA_CNT_W-1:0] sat_inc7(input logic [DNA_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/dna_port_responder.sv
// Stand-in for the 7-series DNA primitive. Holds a programmable fuse value,
// loads it into a shift register on READ and shifts it out MSB first on
// SHIFT, while tracking shift/load statistics and READ+SHIFT overlaps.
//
// Ports:
//   clk, rst_n          DNA port clock, async active-low reset
//   cfg_dna, cfg_load   new fuse value and its one-cycle load strobe
//   dnap_read           load fuse into shift register
//   dnap_shift          shift enable, dnap_din enters at the LSB
//   dnap_dout           shift register MSB (combinational)
//   shift_count         shifts since last READ, saturates at 127
//   exhausted           every fuse bit has been shifted out
//   load_count          READ loads since reset, saturating
//   err_overlap         sticky READ+SHIFT overlap flag, cleared by err_clear
//
// state        | meaning
// -------------+---------------------------------------------------
// ST_IDLE      | no READ since reset; shifts do not count
// ST_LOADED    | fuse loaded, no shifts yet
// ST_SHIFTING  | fuse bits still emerging on dnap_dout
// ST_EXHAUSTED | all fuse bits out; dout carries delayed DIN bits
module dna_port_responder #(
   parameter int                   DNA_WIDTH   = dna_pkg::DNA_WIDTH,
   parameter logic [DNA_WIDTH-1:0] DEFAULT_DNA = '0,
   parameter int                   CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DNA_WIDTH-1:0] cfg_dna,
   input  logic                 cfg_load,
   input  logic                 dnap_read,
   input  logic                 dnap_shift,
   input  logic                 dnap_din,
   output logic                 dnap_dout,
   output logic [6:0]           shift_count,
   output logic                 exhausted,
   output logic [CNT_WIDTH-1:0] load_count,
   output logic                 err_overlap,
   input  logic                 err_clear
);
   import dna_pkg::*;

   localparam logic [6:0] EXH_COUNT = 7'(DNA_WIDTH);

   logic [DNA_WIDTH-1:0] fuse;
   logic [DNA_WIDTH-1:0] sr;
   dna_state_e           state;
   logic [6:0]           cnt_inc;

   assign cnt_inc   = sat_inc7(shift_count);
   assign dnap_dout = sr[DNA_WIDTH-1];
   assign exhausted = (state == ST_EXHAUSTED);

   // Fuse only changes the value seen by the next READ; a READ on the same
   // edge still captures the old fuse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fuse <= DEFAULT_DNA;
      end else if (cfg_load) begin
         fuse <= cfg_dna;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr          <= '0;
         shift_count <= '0;
         load_count  <= '0;
         state       <= ST_IDLE;
      end else if (dnap_read) begin
         sr          <= fuse;
         shift_count <= '0;
         state       <= ST_LOADED;
         if (load_count != {CNT_WIDTH{1'b1}}) begin
            load_count <= load_count + 1'b1;
         end
      end else if (dnap_shift) begin
         // The register shifts even before the first READ; only the
         // statistics wait for a load.
         sr <= {sr[DNA_WIDTH-2:0], dnap_din};
         if (state != ST_IDLE) begin
            shift_count <= cnt_inc;
            state       <= (cnt_inc >= EXH_COUNT) ? ST_EXHAUSTED : ST_SHIFTING;
         end
      end
   end

   // A set on the same edge as err_clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_overlap <= 1'b0;
      end else if (dnap_read && dnap_shift) begin
         err_overlap <= 1'b1;
      end else if (err_clear) begin
         err_overlap <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dna_port_responder.sv
module tb_dna_port_responder;

   localparam int            W   = 57;
   localparam logic [W-1:0]  DEF = 57'h1AB_CDEF_0123_4567;
   localparam logic [W-1:0]  ALT = 57'h155_5555_5555_5555;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  cfg_dna = '0;
   logic          cfg_load = 1'b0;
   logic          dnap_read = 1'b0;
   logic          dnap_shift = 1'b0;
   logic          dnap_din = 1'b0;
   logic          dnap_dout;
   logic [6:0]    shift_count;
   logic          exhausted;
   logic [15:0]   load_count;
   logic          err_overlap;
   logic          err_clear = 1'b0;

   int checks = 0;
   int errors = 0;

   // Reference model: the serial stream as a FIFO of bits (front = dout).
   bit           mq[$];
   logic [W-1:0] mfuse;
   int           mcnt;
   int           mload;
   bit           merr;
   bit           mloaded;

   always #5 clk = ~clk;

   dna_port_responder #(.DNA_WIDTH(W), .DEFAULT_DNA(DEF), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_dna(cfg_dna), .cfg_load(cfg_load),
      .dnap_read(dnap_read), .dnap_shift(dnap_shift), .dnap_din(dnap_din),
      .dnap_dout(dnap_dout), .shift_count(shift_count), .exhausted(exhausted),
      .load_count(load_count), .err_overlap(err_overlap), .err_clear(err_clear)
   );

   function automatic void m_reset();
      mfuse = DEF;
      mq.delete();
      for (int i = 0; i < W; i++) mq.push_back(1'b0);
      mcnt = 0;
      mload = 0;
      merr = 1'b0;
      mloaded = 1'b0;
   endfunction

   // One clock: drive on the falling edge, update the model at the rising
   // edge, return 1 time unit later so outputs are sampled off the edge.
   task automatic cyc(input bit rd, input bit sh, input bit di, input bit cl,
                      input logic [W-1:0] cd, input bit clr);
      @(negedge clk);
      dnap_read = rd; dnap_shift = sh; dnap_din = di;
      cfg_load = cl; cfg_dna = cd; err_clear = clr;
      @(posedge clk);
      if (rd) begin
         mq.delete();
         for (int i = W - 1; i >= 0; i--) mq.push_back(mfuse[i]);
         mcnt = 0;
         if (mload < 65535) mload++;
         mloaded = 1'b1;
      end else if (sh) begin
         void'(mq.pop_front());
         mq.push_back(di);
         if (mloaded && mcnt < 127) mcnt++;
      end
      if (rd && sh) merr = 1'b1;
      else if (clr) merr = 1'b0;
      if (cl) mfuse = cd;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      m_reset();
      #12;
      checks++; if (dnap_dout !== 1'b0) begin errors++; $display("FAIL reset_dout got %b exp 0", dnap_dout); end
      checks++; if (shift_count !== 7'd0) begin errors++; $display("FAIL reset_shift_count got %0d exp 0", shift_count); end
      checks++; if (load_count !== 16'd0) begin errors++; $display("FAIL reset_load_count got %0d exp 0", load_count); end
      checks++; if (err_overlap !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_overlap); end
      checks++; if (exhausted !== 1'b0) begin errors++; $display("FAIL reset_exhausted got %b exp 0", exhausted); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_stream();
      logic [W-1:0] cap;
      cyc(1, 0, 0, 0, '0, 0);
      cap[W-1] = dnap_dout;
      for (int k = 1; k < W; k++) begin
         cyc(0, 1, 1, 0, '0, 0);
         cap[W-1-k] = dnap_dout;
      end
      checks++; if (cap !== DEF) begin errors++; $display("FAIL stream got %h exp %h", cap, DEF); end
      checks++; if (load_count !== 16'd1) begin errors++; $display("FAIL stream_load_count got %0d exp 1", load_count); end
      checks++; if (exhausted !== 1'b0) begin errors++; $display("FAIL stream_exhausted_56 got %b exp 0", exhausted); end
      checks++; if (shift_count !== 7'd56) begin errors++; $display("FAIL stream_shift_count got %0d exp 56", shift_count); end
   endtask

   task automatic test_exhaust();
      for (int n = 57; n <= 130; n++) begin
         cyc(0, 1, 1, 0, '0, 0);
         if (n == 57) begin
            checks++; if (exhausted !== 1'b1) begin errors++; $display("FAIL exhausted_57 got %b exp 1", exhausted); end
         end
         if (n <= 113) begin
            checks++; if (dnap_dout !== 1'b1) begin errors++; $display("FAIL din_passthru shift %0d got %b exp 1", n, dnap_dout); end
         end
         checks++; if (shift_count !== 7'(mcnt)) begin errors++; $display("FAIL exhaust_shift_count shift %0d got %0d exp %0d", n, shift_count, mcnt); end
      end
      checks++; if (shift_count !== 7'd127) begin errors++; $display("FAIL shift_count_sat got %0d exp 127", shift_count); end
      checks++; if (exhausted !== 1'b1) begin errors++; $display("FAIL exhausted_sat got %b exp 1", exhausted); end
   endtask

   task automatic test_overlap();
      cyc(1, 1, 0, 0, '0, 0);
      checks++; if (shift_count !== 7'd0) begin errors++; $display("FAIL overlap_shift_count got %0d exp 0", shift_count); end
      checks++; if (err_overlap !== 1'b1) begin errors++; $display("FAIL overlap_set got %b exp 1", err_overlap); end
      checks++; if (dnap_dout !== DEF[W-1]) begin errors++; $display("FAIL overlap_dout got %b exp %b", dnap_dout, DEF[W-1]); end
      checks++; if (load_count !== 16'd2) begin errors++; $display("FAIL overlap_load_count got %0d exp 2", load_count); end
      cyc(0, 0, 0, 0, '0, 1);
      checks++; if (err_overlap !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err_overlap); end
      cyc(1, 1, 0, 0, '0, 1);
      checks++; if (err_overlap !== 1'b1) begin errors++; $display("FAIL set_beats_clear got %b exp 1", err_overlap); end
      cyc(0, 0, 0, 0, '0, 1);
      checks++; if (err_overlap !== 1'b0) begin errors++; $display("FAIL err_clear2 got %b exp 0", err_overlap); end
   endtask

   task automatic test_cfg_load();
      logic [W-1:0] cap;
      logic [W-1:0] rnd;
      logic [63:0]  t;
      cyc(1, 0, 0, 0, '0, 0);
      cap[W-1] = dnap_dout;
      for (int k = 1; k < W; k++) begin
         cyc(0, 1, 0, (k == 10), ALT, 0);
         cap[W-1-k] = dnap_dout;
      end
      checks++; if (cap !== DEF) begin errors++; $display("FAIL cfg_midstream got %h exp %h", cap, DEF); end
      t = {$urandom(), $urandom()};
      rnd = t[W-1:0];
      // cfg_load together with READ: this READ must still see ALT.
      cyc(1, 0, 0, 1, rnd, 0);
      checks++; if (dnap_dout !== 1'b1) begin errors++; $display("FAIL cfg_first_bit got %b exp 1", dnap_dout); end
      cap[W-1] = dnap_dout;
      for (int k = 1; k < W; k++) begin
         cyc(0, 1, 0, 0, '0, 0);
         cap[W-1-k] = dnap_dout;
      end
      checks++; if (cap !== ALT) begin errors++; $display("FAIL cfg_new_stream got %h exp %h", cap, ALT); end
      cyc(1, 0, 0, 0, '0, 0);
      cap[W-1] = dnap_dout;
      for (int k = 1; k < W; k++) begin
         cyc(0, 1, 0, 0, '0, 0);
         cap[W-1-k] = dnap_dout;
      end
      checks++; if (cap !== rnd) begin errors++; $display("FAIL cfg_same_edge got %h exp %h", cap, rnd); end
   endtask

   task automatic test_async_reset();
      cyc(1, 0, 0, 0, '0, 0);
      for (int k = 0; k < 20; k++) cyc(0, 1, 1, 0, '0, 0);
      cyc(0, 0, 0, 0, '0, 0);
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      checks++; if (dnap_dout !== 1'b0) begin errors++; $display("FAIL arst_dout got %b exp 0", dnap_dout); end
      checks++; if (shift_count !== 7'd0) begin errors++; $display("FAIL arst_shift_count got %0d exp 0", shift_count); end
      checks++; if (load_count !== 16'd0) begin errors++; $display("FAIL arst_load_count got %0d exp 0", load_count); end
      checks++; if (err_overlap !== 1'b0 || exhausted !== 1'b0) begin errors++; $display("FAIL arst_flags got err %b exh %b exp 0 0", err_overlap, exhausted); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_idle_shift();
      bit d;
      for (int k = 0; k < 70; k++) begin
         d = 1'($urandom_range(0, 1));
         cyc(0, 1, d, 0, '0, 0);
         checks++; if (shift_count !== 7'd0 || exhausted !== 1'b0) begin errors++; $display("FAIL idle_count got cnt %0d exh %b exp 0 0", shift_count, exhausted); end
         checks++; if (dnap_dout !== mq[0]) begin errors++; $display("FAIL idle_dout step %0d got %b exp %b", k, dnap_dout, mq[0]); end
      end
   endtask

   task automatic test_random();
      bit rd, sh, di, cl, clr;
      logic [63:0] t;
      for (int k = 0; k < 600; k++) begin
         rd  = ($urandom_range(0, 19) == 0);
         sh  = ($urandom_range(0, 3) != 0);
         di  = 1'($urandom_range(0, 1));
         cl  = ($urandom_range(0, 29) == 0);
         clr = ($urandom_range(0, 9) == 0);
         t   = {$urandom(), $urandom()};
         cyc(rd, sh, di, cl, t[W-1:0], clr);
         checks++; if (dnap_dout !== mq[0]) begin errors++; $display("FAIL rand_dout step %0d got %b exp %b", k, dnap_dout, mq[0]); end
         checks++; if (shift_count !== 7'(mcnt)) begin errors++; $display("FAIL rand_shift_count step %0d got %0d exp %0d", k, shift_count, mcnt); end
         checks++; if (exhausted !== (mcnt >= W)) begin errors++; $display("FAIL rand_exhausted step %0d got %b exp %b", k, exhausted, (mcnt >= W)); end
         checks++; if (load_count !== 16'(mload)) begin errors++; $display("FAIL rand_load_count step %0d got %0d exp %0d", k, load_count, mload); end
         checks++; if (err_overlap !== merr) begin errors++; $display("FAIL rand_err step %0d got %b exp %b", k, err_overlap, merr); end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_exhaust();
      test_overlap();
      test_cfg_load();
      test_async_reset();
      test_idle_shift();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
